adc_capture_sequencer: RTL and testbench
========================================

ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, sample width; ADDR_W, default 13, RAM address width; MAX_LEN, default 4096, maximum samples per capture.
REQ-002 Ports SHALL be, one per line: name direction width meaning. Clock and reset are listed first.
  sys_clk  in  1  single clock, 65 MHz nominal; all logic on its rising edge
  sys_rst_n  in  1  asynchronous, active-low reset
  adc_sample_in  in  DATA_W  ADC sample
  adc_valid_i  in  1  adc_sample_in valid this cycle
  csr_arm_i  in  1  one-cycle arm pulse
  csr_abort_i  in  1  one-cycle abort pulse
  csr_sw_trig_i  in  1  one-cycle software trigger
  trig_ext_i  in  1  external trigger level; asynchronous source, already synchronised upstream
  csr_trig_mode_i  in  2  0 = immediate, 1 = ext rising edge, 2 = software, 3 = reserved (behaves as 0)
  csr_decim_i  in  8  keep 1 of every (csr_decim_i+1) valid samples
  csr_len_i  in  ADDR_W  capture length in samples
  csr_base_i  in  ADDR_W  RAM start address
  mem_we_o  out  1  RAM write strobe
  mem_addr_o  out  ADDR_W  RAM write address
  mem_data_o  out  DATA_W  RAM write data
  csr_busy_o  out  1  state is ARMED or CAPTURE
  csr_done_o  out  1  sticky capture-complete flag
  csr_count_o  out  ADDR_W  samples written in the current/last capture
  csr_state_o  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ARMED, CAPTURE, DONE.
REQ-004 In IDLE or DONE, csr_arm_i SHALL latch csr_trig_mode_i, csr_decim_i, csr_len_i and csr_base_i, clear csr_done_o and csr_count_o, and enter ARMED on the next edge.
REQ-005 csr_arm_i SHALL be ignored in ARMED and CAPTURE; CSR input changes after arming SHALL have no effect until the next arm.
REQ-006 Effective length: latched csr_len_i == 0 or > MAX_LEN SHALL be treated as MAX_LEN.
REQ-007 Trigger conditions SHALL move ARMED to CAPTURE on the next edge.
  - Mode 0/3: unconditional; ARMED lasts exactly one cycle.
  - Mode 1: trig_ext_i high this cycle and low the previous cycle. The edge-detect register SHALL update every cycle, so a level already high at arm time does not trigger.
  - Mode 2: csr_sw_trig_i high.
  - Triggers outside ARMED SHALL be ignored.
REQ-008 On CAPTURE entry, the decimation counter SHALL reset so that the first valid sample seen in CAPTURE is kept.
  - After that, every (decim+1)-th valid sample is kept.
  - Cycles with adc_valid_i low SHALL NOT advance the counter.
REQ-009 Write timing for a kept sample:
  - On the following edge, mem_we_o = 1 for exactly one cycle, mem_data_o = that sample, mem_addr_o = (base + index) mod 2^ADDR_W, where index starts at 0.
  - Write latency SHALL be 1 cycle.
  - csr_count_o SHALL increment in the same cycle that mem_we_o is asserted.
REQ-010 Address arithmetic SHALL wrap modulo 2^ADDR_W; there is no error on wrap.
REQ-011 When the write of sample number len is issued (csr_count_o becomes len), the FSM SHALL enter DONE on that same edge.
  - csr_done_o SHALL be 1 from that edge and remain 1 until the next arm, abort or reset.
  - No further writes SHALL occur.
REQ-012 mem_addr_o and mem_data_o SHALL hold their last values when mem_we_o = 0.
REQ-013 csr_abort_i in any state SHALL force IDLE on the next edge.
  - It clears csr_done_o and suppresses any pending write.
  - csr_count_o is retained.
REQ-014 When csr_arm_i and csr_abort_i are high in the same cycle, abort SHALL win.
REQ-015 Simultaneous trigger and abort in ARMED SHALL result in IDLE.

Reset
REQ-016 sys_rst_n low SHALL, asynchronously:
  - set state to IDLE;
  - set mem_we_o = 0, csr_done_o = 0, csr_busy_o = 0;
  - set csr_count_o, mem_addr_o, mem_data_o, csr_state_o and all latched configuration to 0;
  - clear the edge-detect register.
REQ-017 Reset asserted mid-capture SHALL abandon the capture; no write SHALL occur in the cycle in which reset is deasserted.

Verification
REQ-018 Scenario: mode 0, decim 0, len 4096, base 0x400, adc_valid_i always high, data = index.
  - Required: 4096 single-cycle writes, addresses 0x400..0x13FF, data 0..4095.
  - Required: csr_done_o = 1 on the edge of the last write; csr_count_o = 4096; no further mem_we_o.
REQ-019 Scenario: mode 1, trig_ext_i already high at arm, then low for 3 cycles, then high.
  - Required: no capture until the new rising edge; the first sample is written 1 cycle after the first valid sample following that edge.
REQ-020 Scenario: decim 3, len 8, adc_valid_i toggling 1/0.
  - Required: exactly 8 writes, one every 8 cycles.
  - Required: written data equals valid samples 0, 4, 8, ..., 28.
REQ-021 Scenario: base 0x1FFE, len 4.
  - Required: addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-022 Scenario: abort after 100 writes, then arm and abort asserted together, then a re-arm.
  - Required: the first abort gives IDLE, csr_done_o = 0, csr_count_o = 100.
  - Required: the simultaneous arm+abort leaves the block in IDLE.
  - Required: the re-arm clears csr_count_o to 0.
REQ-023 Scenario: sys_rst_n pulsed low mid-CAPTURE.
  - Required: all outputs at reset values immediately.
  - Required: no write after release until a new arm.

Source files
------------

// File: rtl/adc_capture_sequencer.sv
// Purpose : arms on a CSR pulse, waits for a trigger, then decimates ADC samples into a RAM window.
// Latency : a kept sample is written to RAM 1 cycle after it is presented (registered write port).
// Backpress: none; the ADC stream cannot be stalled, so samples arriving outside CAPTURE are dropped.
//
// Ports
//   sys_clk, sys_rst_n      : clock, asynchronous active-low reset
//   adc_sample_in/valid_i   : incoming sample stream
//   csr_arm_i/abort_i       : one-cycle control pulses (abort has priority over everything)
//   csr_sw_trig_i/trig_ext_i: software trigger pulse / synchronised external trigger level
//   csr_trig_mode_i         : 0 immediate, 1 ext rising edge, 2 software, 3 same as 0
//   csr_decim_i             : keep 1 of every (decim+1) valid samples
//   csr_len_i/csr_base_i    : capture length (0 or > MAX_LEN means MAX_LEN) and RAM start address
//   mem_*_o                 : RAM write port; address/data hold when mem_we_o is low
//   csr_busy/done/count/state_o : status
module adc_capture_sequencer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 13,
    parameter int MAX_LEN = 4096
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] adc_sample_in,
    input  logic              adc_valid_i,
    input  logic              csr_arm_i,
    input  logic              csr_abort_i,
    input  logic              csr_sw_trig_i,
    input  logic              trig_ext_i,
    input  logic [1:0]        csr_trig_mode_i,
    input  logic [7:0]        csr_decim_i,
    input  logic [ADDR_W-1:0] csr_len_i,
    input  logic [ADDR_W-1:0] csr_base_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              csr_busy_o,
    output logic              csr_done_o,
    output logic [ADDR_W-1:0] csr_count_o,
    output logic [1:0]        csr_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Length is held one bit wider than the address so MAX_LEN == 2**ADDR_W
    // would still be representable.
    localparam logic [31:0]     MAX_LEN_32 = MAX_LEN;
    localparam logic [ADDR_W:0] MAX_LEN_W  = MAX_LEN_32[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_W      = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;

    logic [1:0]        cfg_mode;
    logic [7:0]        cfg_decim;
    logic [ADDR_W:0]   cfg_len;
    logic [ADDR_W-1:0] cfg_base;

    logic [7:0]        dec_cnt;
    logic              trig_q;
    logic              trig_hit;
    logic              arm_go;
    logic              keep;
    logic              last;

    logic [ADDR_W:0]   len_in;
    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W:0]   count_ext;

    assign len_in    = {1'b0, csr_len_i};
    assign len_eff   = ((len_in == '0) || (len_in > MAX_LEN_W)) ? MAX_LEN_W : len_in;
    assign count_ext = {1'b0, csr_count_o} + ONE_W;

    assign csr_busy_o  = (state == ARMED) || (state == CAPTURE);
    assign csr_state_o = state;

    // Trigger qualifier uses the latched mode so CSR writes after arming do nothing.
    always_comb begin
        trig_hit = 1'b1;
        case (cfg_mode)
            2'd1:    trig_hit = trig_ext_i & ~trig_q;
            2'd2:    trig_hit = csr_sw_trig_i;
            default: trig_hit = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort overrides every other event, including a same-cycle arm or trigger
    // and a sample that would otherwise be written.
    always_comb begin
        state_nxt = state;
        arm_go    = 1'b0;
        keep      = 1'b0;
        last      = 1'b0;
        if (csr_abort_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (csr_arm_i) begin
                        state_nxt = ARMED;
                        arm_go    = 1'b1;
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (adc_valid_i && (dec_cnt == 8'd0)) begin
                        keep = 1'b1;
                        if (count_ext == cfg_len) begin
                            last      = 1'b1;
                            state_nxt = DONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            csr_done_o  <= 1'b0;
            csr_count_o <= '0;
            cfg_mode    <= 2'd0;
            cfg_decim   <= 8'd0;
            cfg_len     <= '0;
            cfg_base    <= '0;
            dec_cnt     <= 8'd0;
            trig_q      <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            // Edge history tracks the pin in every state, so a level that is
            // already high when the block arms is not seen as an edge.
            trig_q   <= trig_ext_i;

            if (arm_go) begin
                cfg_mode    <= csr_trig_mode_i;
                cfg_decim   <= csr_decim_i;
                cfg_len     <= len_eff;
                cfg_base    <= csr_base_i;
                csr_count_o <= '0;
                csr_done_o  <= 1'b0;
            end

            if (csr_abort_i) begin
                csr_done_o <= 1'b0;
            end

            // Held at zero while armed so the first valid sample in CAPTURE is kept;
            // only valid cycles advance it.
            if (state == ARMED) begin
                dec_cnt <= 8'd0;
            end else if ((state == CAPTURE) && adc_valid_i) begin
                dec_cnt <= (dec_cnt == cfg_decim) ? 8'd0 : dec_cnt + 8'd1;
            end

            if (keep) begin
                mem_we_o    <= 1'b1;
                mem_addr_o  <= cfg_base + csr_count_o;
                mem_data_o  <= adc_sample_in;
                csr_count_o <= count_ext[ADDR_W-1:0];
                if (last) begin
                    csr_done_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
`timescale 1ns/1ps
module tb_adc_capture_sequencer;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 13;
    localparam int MAX_LEN = 4096;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic [DATA_W-1:0] adc_sample_in = '0;
    logic              adc_valid_i = 1'b0;
    logic              csr_arm_i = 1'b0;
    logic              csr_abort_i = 1'b0;
    logic              csr_sw_trig_i = 1'b0;
    logic              trig_ext_i = 1'b0;
    logic [1:0]        csr_trig_mode_i = 2'd0;
    logic [7:0]        csr_decim_i = 8'd0;
    logic [ADDR_W-1:0] csr_len_i = '0;
    logic [ADDR_W-1:0] csr_base_i = '0;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              csr_busy_o;
    logic              csr_done_o;
    logic [ADDR_W-1:0] csr_count_o;
    logic [1:0]        csr_state_o;

    adc_capture_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .adc_sample_in  (adc_sample_in),
        .adc_valid_i    (adc_valid_i),
        .csr_arm_i      (csr_arm_i),
        .csr_abort_i    (csr_abort_i),
        .csr_sw_trig_i  (csr_sw_trig_i),
        .trig_ext_i     (trig_ext_i),
        .csr_trig_mode_i(csr_trig_mode_i),
        .csr_decim_i    (csr_decim_i),
        .csr_len_i      (csr_len_i),
        .csr_base_i     (csr_base_i),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .csr_busy_o     (csr_busy_o),
        .csr_done_o     (csr_done_o),
        .csr_count_o    (csr_count_o),
        .csr_state_o    (csr_state_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [7:0]  decim;
        logic [12:0] len;
        logic [12:0] base;
        bit          toggle;          // adc_valid_i alternates 1/0 from CAPTURE entry
        int          exp_writes;
        int          exp_gap;         // cycles between consecutive writes
        logic [12:0] exp_first_addr;
        logic [12:0] exp_last_addr;
        logic [31:0] exp_last_data;
    } vec_t;

    vec_t vecs [8];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Arms with the vector's configuration, fires its trigger, then runs the
    // sample stream while checking every write against the expected pattern.
    // abort_after >= 0 aborts once that many writes have been seen; arm_at
    // pulses csr_arm_i in that CAPTURE cycle (it must be ignored).
    task automatic run_capture(input vec_t v, input int abort_after, input int arm_at);
        int k;
        int vidx;
        int limit;
        int extra;
        bit aborted;
        bit vld;
        logic [12:0] ea;
        k = 0;
        vidx = 0;
        extra = 0;
        aborted = 1'b0;
        adc_valid_i = 1'b0;
        trig_ext_i = (v.mode == 2'd1);
        csr_trig_mode_i = v.mode;
        csr_decim_i = v.decim;
        csr_len_i = v.len;
        csr_base_i = v.base;
        csr_arm_i = 1'b1;
        tick();
        csr_arm_i = 1'b0;
        // Scrambled CSRs after arming must not alter the capture.
        csr_trig_mode_i = v.mode ^ 2'b10;
        csr_decim_i = v.decim + 8'd5;
        csr_len_i = v.len + 13'd3;
        csr_base_i = v.base + 13'd7;
        chk({v.name, " armed state"}, 64'(csr_state_o), 64'd1);
        chk({v.name, " armed busy"}, 64'(csr_busy_o), 64'd1);
        chk({v.name, " armed done"}, 64'(csr_done_o), 64'd0);
        chk({v.name, " armed count"}, 64'(csr_count_o), 64'd0);
        if (v.mode == 2'd1) begin
            tick();
            chk({v.name, " high-at-arm no trigger"}, 64'(csr_state_o), 64'd1);
            trig_ext_i = 1'b0;
            repeat (3) begin
                tick();
                chk({v.name, " low level no trigger"}, 64'(csr_state_o), 64'd1);
            end
            trig_ext_i = 1'b1;
        end else if (v.mode == 2'd2) begin
            repeat (2) begin
                tick();
                chk({v.name, " waiting sw trigger"}, 64'(csr_state_o), 64'd1);
            end
            csr_sw_trig_i = 1'b1;
        end
        // Samples presented while ARMED must never be written.
        adc_valid_i = 1'b1;
        adc_sample_in = 32'hDEAD_BEEF;
        tick();
        csr_sw_trig_i = 1'b0;
        chk({v.name, " capture entry"}, 64'(csr_state_o), 64'd2);
        chk({v.name, " no write from armed"}, 64'(mem_we_o), 64'd0);

        limit = v.exp_writes * v.exp_gap + 40;
        for (int c = 0; c < limit && k < v.exp_writes; c++) begin
            vld = v.toggle ? (c % 2 == 0) : 1'b1;
            adc_valid_i = vld;
            adc_sample_in = vld ? 32'(vidx) : (32'hBAD0_0000 | 32'(c));
            if (abort_after >= 0 && k == abort_after) begin
                csr_abort_i = 1'b1;
                tick();
                csr_abort_i = 1'b0;
                chk({v.name, " abort state"}, 64'(csr_state_o), 64'd0);
                chk({v.name, " abort done"}, 64'(csr_done_o), 64'd0);
                chk({v.name, " abort count kept"}, 64'(csr_count_o), 64'(abort_after));
                chk({v.name, " abort suppresses write"}, 64'(mem_we_o), 64'd0);
                aborted = 1'b1;
                break;
            end
            csr_arm_i = (c == arm_at);
            tick();
            csr_arm_i = 1'b0;
            if (vld) vidx++;
            if (mem_we_o) begin
                ea = v.exp_first_addr + 13'(k);
                chk({v.name, " write cycle"}, 64'(c), 64'(k * v.exp_gap));
                chk({v.name, " write addr"}, 64'(mem_addr_o), 64'(ea));
                chk({v.name, " write data"}, 64'(mem_data_o), 64'(k * (int'(v.decim) + 1)));
                k++;
                chk({v.name, " count with write"}, 64'(csr_count_o), 64'(k));
                if (k == v.exp_writes) begin
                    chk({v.name, " done on last write"}, 64'(csr_done_o), 64'd1);
                    chk({v.name, " state DONE"}, 64'(csr_state_o), 64'd3);
                    chk({v.name, " busy cleared"}, 64'(csr_busy_o), 64'd0);
                    chk({v.name, " last addr"}, 64'(mem_addr_o), 64'(v.exp_last_addr));
                    chk({v.name, " last data"}, 64'(mem_data_o), 64'(v.exp_last_data));
                end else begin
                    chk({v.name, " done low mid-capture"}, 64'(csr_done_o), 64'd0);
                end
            end
        end
        if (!aborted) begin
            chk({v.name, " total writes"}, 64'(k), 64'(v.exp_writes));
        end
        adc_valid_i = 1'b1;
        repeat (20) begin
            tick();
            if (mem_we_o) extra++;
        end
        adc_valid_i = 1'b0;
        chk({v.name, " no further writes"}, 64'(extra), 64'd0);
        if (!aborted) begin
            chk({v.name, " addr held"}, 64'(mem_addr_o), 64'(v.exp_last_addr));
            chk({v.name, " done sticky"}, 64'(csr_done_o), 64'd1);
        end
    endtask

    initial begin
        int extra;
        vecs[0] = '{"full_len",   2'd0, 8'd0,   13'd4096, 13'h0400, 1'b0, 4096, 1,   13'h0400, 13'h13FF, 32'd4095};
        vecs[1] = '{"ext_edge",   2'd1, 8'd0,   13'd3,    13'h0020, 1'b0, 3,    1,   13'h0020, 13'h0022, 32'd2};
        vecs[2] = '{"decim3",     2'd0, 8'd3,   13'd8,    13'h0000, 1'b1, 8,    8,   13'h0000, 13'h0007, 32'd28};
        vecs[3] = '{"wrap",       2'd0, 8'd0,   13'd4,    13'h1FFE, 1'b0, 4,    1,   13'h1FFE, 13'h0001, 32'd3};
        vecs[4] = '{"sw_trig",    2'd2, 8'd1,   13'd3,    13'h0010, 1'b0, 3,    2,   13'h0010, 13'h0012, 32'd4};
        vecs[5] = '{"len0_mode3", 2'd3, 8'd0,   13'd0,    13'h0100, 1'b0, 4096, 1,   13'h0100, 13'h10FF, 32'd4095};
        vecs[6] = '{"len_over",   2'd0, 8'd0,   13'd5000, 13'h0000, 1'b0, 4096, 1,   13'h0000, 13'h0FFF, 32'd4095};
        vecs[7] = '{"decim255",   2'd0, 8'd255, 13'd2,    13'h0005, 1'b0, 2,    256, 13'h0005, 13'h0006, 32'd256};

        // Reset values while reset is held.
        #3;
        chk("reset we", 64'(mem_we_o), 64'd0);
        chk("reset addr", 64'(mem_addr_o), 64'd0);
        chk("reset data", 64'(mem_data_o), 64'd0);
        chk("reset busy", 64'(csr_busy_o), 64'd0);
        chk("reset done", 64'(csr_done_o), 64'd0);
        chk("reset count", 64'(csr_count_o), 64'd0);
        chk("reset state", 64'(csr_state_o), 64'd0);
        #20;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();

        // Triggers while IDLE are ignored.
        csr_sw_trig_i = 1'b1;
        trig_ext_i = 1'b1;
        adc_valid_i = 1'b1;
        tick();
        csr_sw_trig_i = 1'b0;
        trig_ext_i = 1'b0;
        adc_valid_i = 1'b0;
        chk("idle trigger ignored", 64'(csr_state_o), 64'd0);
        chk("idle no write", 64'(mem_we_o), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_capture(vecs[i], -1, -1);
        end

        // Abort from DONE clears the sticky flag but keeps the count.
        csr_abort_i = 1'b1;
        tick();
        csr_abort_i = 1'b0;
        chk("abort from done state", 64'(csr_state_o), 64'd0);
        chk("abort from done flag", 64'(csr_done_o), 64'd0);
        chk("abort from done count", 64'(csr_count_o), 64'd2);

        // Abort after 100 writes, with a stray arm mid-capture.
        run_capture('{"abort100", 2'd0, 8'd0, 13'd200, 13'h0000, 1'b0, 200, 1,
                      13'h0000, 13'h00C7, 32'd199}, 100, 50);
        csr_arm_i = 1'b1;
        csr_abort_i = 1'b1;
        tick();
        csr_arm_i = 1'b0;
        csr_abort_i = 1'b0;
        chk("arm+abort state", 64'(csr_state_o), 64'd0);
        chk("arm+abort count", 64'(csr_count_o), 64'd100);
        csr_trig_mode_i = 2'd2;
        csr_arm_i = 1'b1;
        tick();
        csr_arm_i = 1'b0;
        chk("rearm state", 64'(csr_state_o), 64'd1);
        chk("rearm clears count", 64'(csr_count_o), 64'd0);

        // Software trigger and abort together while ARMED.
        csr_sw_trig_i = 1'b1;
        csr_abort_i = 1'b1;
        adc_valid_i = 1'b1;
        tick();
        csr_sw_trig_i = 1'b0;
        csr_abort_i = 1'b0;
        chk("trig+abort state", 64'(csr_state_o), 64'd0);
        extra = 0;
        repeat (5) begin
            tick();
            if (mem_we_o) extra++;
        end
        chk("trig+abort no writes", 64'(extra), 64'd0);

        // Reset pulsed mid-CAPTURE.
        csr_trig_mode_i = 2'd0;
        csr_decim_i = 8'd0;
        csr_len_i = 13'd100;
        csr_base_i = 13'h0123;
        adc_sample_in = 32'h5555_AAAA;
        csr_arm_i = 1'b1;
        tick();
        csr_arm_i = 1'b0;
        repeat (6) tick();
        chk("pre-reset capturing", 64'(csr_state_o), 64'd2);
        chk("pre-reset writing", 64'(mem_we_o), 64'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("async reset we", 64'(mem_we_o), 64'd0);
        chk("async reset addr", 64'(mem_addr_o), 64'd0);
        chk("async reset data", 64'(mem_data_o), 64'd0);
        chk("async reset busy", 64'(csr_busy_o), 64'd0);
        chk("async reset done", 64'(csr_done_o), 64'd0);
        chk("async reset count", 64'(csr_count_o), 64'd0);
        chk("async reset state", 64'(csr_state_o), 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        extra = 0;
        repeat (20) begin
            tick();
            if (mem_we_o) extra++;
        end
        chk("post-reset no writes", 64'(extra), 64'd0);
        chk("post-reset idle", 64'(csr_state_o), 64'd0);
        chk("post-reset count", 64'(csr_count_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so a stuck run still reports.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
